// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: interrupt/trap sequencer in front of the machine-mode CSR file.
// Latches rising edges on irq_src, arbitrates (lowest index wins), handshakes with
// the pipeline to a boundary, then pulses trap entry/exit to the CSR file.
// Optional macro IRQ_TRAP_CTRL_SYNC_EN: adds a 2-flop synchronizer on each irq_src bit.
module irq_trap_ctrl #(
  parameter int unsigned NUM_IRQ  = 16,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_src,
  input  logic [NUM_IRQ-1:0]  irq_en,
  input  logic                int_mstatus_mie,
  output logic                trap_req,
  input  logic                trap_ack,
  input  logic [PC_WIDTH-1:0] pipe_pc,
  input  logic                mret_valid,
  output logic                trap_entry_en,
  output logic                trap_exit_en,
  output logic [3:0]          int_index,
  output logic [PC_WIDTH-1:0] normal_pc,
  output logic [NUM_IRQ-1:0]  pending,
  output logic                busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_ENTRY   = 3'd2;
  localparam logic [2:0] ST_HANDLER = 3'd3;
  localparam logic [2:0] ST_EXIT    = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [NUM_IRQ-1:0]  edge_src;
  logic [NUM_IRQ-1:0]  src_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  eligible, clr, rise;
  logic [3:0]          prio_idx;
  logic [3:0]          sel_idx_q, sel_idx_d;
  logic                capture;
  logic                trap_req_q, trap_entry_en_q, trap_exit_en_q, busy_q;
  logic [3:0]          int_index_q;
  logic [PC_WIDTH-1:0] normal_pc_q;

`ifdef IRQ_TRAP_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer for asynchronous interrupt sources.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign edge_src = sync2_q;
`else
  assign edge_src = irq_src;
`endif

  // Rising-edge detect, eligibility and entry-time clear mask.
  always_comb begin
    rise     = edge_src & ~src_q;
    eligible = pending_q & irq_en;
    clr      = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      clr[i] = (state_q == ST_ENTRY) && (sel_idx_q == 4'(i));
    end
    // set after clear: a new edge on the bit being serviced is not lost
    pending_d = (pending_q & ~clr) | rise;
  end

  // Fixed-priority encoder, lowest index wins.
  always_comb begin
    prio_idx = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) prio_idx = 4'(i - 1);
    end
  end

  // Edge-detect history and pending latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= edge_src;
      pending_q <= pending_d;
    end
  end

  // Next-state logic for the trap sequencer.
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    capture   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_mstatus_mie && (|eligible)) begin
          state_d   = ST_REQ;
          sel_idx_d = prio_idx;
        end else if (mret_valid) begin
          state_d = ST_EXIT;
        end
      end
      ST_REQ: begin
        if (mret_valid) begin
          state_d = ST_EXIT;
        end else if (!int_mstatus_mie) begin
          state_d = ST_IDLE;
        end else if (trap_ack) begin
          state_d = ST_ENTRY;
          capture = 1'b1;
        end
      end
      ST_ENTRY:   state_d = ST_HANDLER;
      ST_HANDLER: if (mret_valid) state_d = ST_EXIT;
      ST_EXIT:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      sel_idx_q       <= '0;
      trap_req_q      <= 1'b0;
      trap_entry_en_q <= 1'b0;
      trap_exit_en_q  <= 1'b0;
      busy_q          <= 1'b0;
      int_index_q     <= '0;
      normal_pc_q     <= '0;
    end else begin
      state_q         <= state_d;
      sel_idx_q       <= sel_idx_d;
      trap_req_q      <= (state_d == ST_REQ);
      trap_entry_en_q <= (state_d == ST_ENTRY);
      trap_exit_en_q  <= (state_d == ST_EXIT);
      busy_q          <= (state_d != ST_IDLE);
      if (capture) begin
        int_index_q <= sel_idx_q;
        normal_pc_q <= pipe_pc;
      end
    end
  end

  assign trap_req      = trap_req_q;
  assign trap_entry_en = trap_entry_en_q;
  assign trap_exit_en  = trap_exit_en_q;
  assign busy          = busy_q;
  assign int_index     = int_index_q;
  assign normal_pc     = normal_pc_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl (NUM_IRQ=16, PC_WIDTH=32).
`timescale 1ns/1ps
module tb_irq_trap_ctrl;
  localparam int N = 16;
  localparam int W = 32;

  localparam int P_IDLE = 0, P_REQ = 1, P_ENTRY = 2, P_HANDLER = 3, P_EXIT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq_src = '0;
  logic [N-1:0] irq_en = '1;
  logic         mie = 1'b1;
  logic         trap_req;
  logic         trap_ack = 1'b0;
  logic [W-1:0] pipe_pc = '0;
  logic         mret_valid = 1'b0;
  logic         trap_entry_en, trap_exit_en;
  logic [3:0]   int_index;
  logic [W-1:0] normal_pc;
  logic [N-1:0] pending;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  irq_trap_ctrl #(.NUM_IRQ(N), .PC_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .irq_en(irq_en),
    .int_mstatus_mie(mie), .trap_req(trap_req), .trap_ack(trap_ack),
    .pipe_pc(pipe_pc), .mret_valid(mret_valid), .trap_entry_en(trap_entry_en),
    .trap_exit_en(trap_exit_en), .int_index(int_index), .normal_pc(normal_pc),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [N-1:0] v);
    logic [3:0] r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Behavioural model: whole-cycle reaction to the inputs seen at each rising edge.
  int           m_ph = P_IDLE;
  logic [N-1:0] m_pend = '0, m_seen = '0, m_s1 = '0, m_s2 = '0;
  logic [3:0]   m_sel = '0, m_idx = '0;
  logic [W-1:0] m_pc = '0;

  always @(posedge clk) begin
    logic [N-1:0] eff, elig, served;
    if (rst) begin
      m_ph = P_IDLE; m_pend = '0; m_seen = '0; m_s1 = '0; m_s2 = '0;
      m_sel = '0; m_idx = '0; m_pc = '0;
    end else begin
`ifdef IRQ_TRAP_CTRL_SYNC_EN
      eff = m_s2; m_s2 = m_s1; m_s1 = irq_src;
`else
      eff = irq_src;
`endif
      elig   = m_pend & irq_en;
      served = (m_ph == P_ENTRY) ? (N'(1) << m_sel) : '0;
      m_pend = (m_pend & ~served) | (eff & ~m_seen);
      m_seen = eff;
      if (m_ph == P_IDLE) begin
        if (mie && elig != 0) begin m_sel = lowest(elig); m_ph = P_REQ; end
        else if (mret_valid) m_ph = P_EXIT;
      end else if (m_ph == P_REQ) begin
        if (mret_valid) m_ph = P_EXIT;
        else if (!mie) m_ph = P_IDLE;
        else if (trap_ack) begin m_idx = m_sel; m_pc = pipe_pc; m_ph = P_ENTRY; end
      end else if (m_ph == P_ENTRY) m_ph = P_HANDLER;
      else if (m_ph == P_HANDLER) begin
        if (mret_valid) m_ph = P_EXIT;
      end else m_ph = P_IDLE;
    end
    #1;
    check("m_trap_req", trap_req, m_ph == P_REQ);
    check("m_entry", trap_entry_en, m_ph == P_ENTRY);
    check("m_exit", trap_exit_en, m_ph == P_EXIT);
    check("m_busy", busy, m_ph != P_IDLE);
    check("m_index", int_index, m_idx);
    check("m_pc", normal_pc, m_pc);
    check("m_pending", pending, m_pend);
  end

  task automatic wait_req(input int lim, input string name);
    int k = 0;
    while (!trap_req && k < lim) begin
      @(negedge clk);
      k++;
    end
    check(name, trap_req, 1'b1);
  endtask

  // Acknowledge a request and land in the handler.
  task automatic take(input logic [W-1:0] pc, input logic [3:0] idx);
    wait_req(8, "take_req");
    trap_ack = 1'b1;
    pipe_pc  = pc;
    @(negedge clk);
    trap_ack = 1'b0;
    check("entry_pulse", trap_entry_en, 1'b1);
    check("entry_index", int_index, idx);
    check("entry_pc", normal_pc, pc);
    @(negedge clk);
    check("entry_once", trap_entry_en, 1'b0);
    check("pend_cleared", pending[idx], 1'b0);
  endtask

  task automatic do_mret();
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
    check("exit_pulse", trap_exit_en, 1'b1);
    @(negedge clk);
    check("exit_once", trap_exit_en, 1'b0);
    check("idle_after_exit", busy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", trap_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pend", pending, '0);
    check("rst_index", int_index, '0);
    rst = 1'b0;
    @(negedge clk);

    // basic take of source 5
    irq_src[5] = 1'b1;
    @(negedge clk);
    check("basic_pend5", pending[5], 1'b1);
    check("basic_req_early", trap_req, 1'b0);
    @(negedge clk);
    check("basic_req", trap_req, 1'b1);
    irq_src[5] = 1'b0;
    take(32'h0000_0120, 4'd5);
    check("basic_busy", busy, 1'b1);
    do_mret();

    // priority: 2 beats 9, then 9 is taken after exit
    irq_src[9] = 1'b1; irq_src[2] = 1'b1;
    take(32'h200, 4'd2);
    irq_src = '0;
    do_mret();
    take(32'h300, 4'd9);
    do_mret();

    // masking by mie, then by irq_en
    mie = 1'b0;
    irq_src[3] = 1'b1;
    repeat (3) @(negedge clk);
    check("mask_no_req", trap_req, 1'b0);
    check("mask_pend3", pending[3], 1'b1);
    mie = 1'b1;
    wait_req(2, "mie_req");
    take(32'h340, 4'd3);
    irq_src[3] = 1'b0;
    do_mret();
    irq_en = 16'hFFF7;
    irq_src[3] = 1'b1;
    repeat (4) @(negedge clk);
    check("en_no_req", trap_req, 1'b0);
    check("en_pend3", pending[3], 1'b1);
    irq_en = '1;
    take(32'h380, 4'd3);
    irq_src = '0;
    do_mret();

    // withdraw on mie drop, then mret while requesting
    irq_src[7] = 1'b1;
    wait_req(4, "wd_req");
    mie = 1'b0;
    @(negedge clk);
    check("wd_req_low", trap_req, 1'b0);
    check("wd_idle", busy, 1'b0);
    check("wd_pend7", pending[7], 1'b1);
    mie = 1'b1;
    wait_req(4, "wd_req2");
    mret_valid = 1'b1;
    @(negedge clk);
    mret_valid = 1'b0;
    check("reqmret_exit", trap_exit_en, 1'b1);
    check("reqmret_noentry", trap_entry_en, 1'b0);
    @(negedge clk);
    check("reqmret_idle", busy, 1'b0);
    take(32'h400, 4'd7);
    irq_src = '0;
    do_mret();

    // no nesting while in the handler
    irq_src[1] = 1'b1;
    take(32'h500, 4'd1);
    irq_src[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("nest_pend0", pending[0], 1'b1);
    check("nest_no_req", trap_req, 1'b0);
    irq_src = '0;
    do_mret();
    take(32'h600, 4'd0);
    do_mret();

    // asynchronous reset while requesting, then while in the handler
    irq_src[4] = 1'b1;
    wait_req(4, "rst_req_wait");
    #2 rst = 1'b1;
    #1;
    check("arst_req", trap_req, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_pend", pending, '0);
    irq_src = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle", busy, 1'b0);
    irq_src[6] = 1'b1;
    take(32'h700, 4'd6);
    #2 rst = 1'b1;
    #1;
    check("arst2_busy", busy, 1'b0);
    check("arst2_index", int_index, '0);
    irq_src = '0;
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      irq_src    = irq_src ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) irq_en = N'($urandom);
      mie        = ($urandom_range(0, 9) != 0);
      trap_ack   = trap_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      mret_valid = ($urandom_range(0, 15) == 0);
      pipe_pc    = $urandom;
      rst        = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    rst = 1'b0; trap_ack = 1'b0; mret_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_trap_ctrl.md
Name: irq_trap_ctrl

Overview:
- Interrupt/trap sequencer in front of the machine-mode CSR file.
- Latches external interrupt requests, picks the highest-priority enabled one, and handshakes with the pipeline to reach an instruction boundary.
- Drives the CSR file's trap entry/exit controls: trap_entry_en, int_index, normal_pc and trap_exit_en.
- Blocks nesting: no new trap is taken until the handler retires mret.

Parameters:
- NUM_IRQ, 16, number of interrupt sources; legal range 1..16 because int_index is 4 bits.
- PC_WIDTH, 32, width of the PC captured into mepc.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- irq_src  in  NUM_IRQ  raw interrupt lines; a rising edge means a request.
- irq_en  in  NUM_IRQ  per-source enable mask.
- int_mstatus_mie  in  1  global interrupt enable (mstatus.MIE) from the CSR file.
- trap_req  out  1  request to the pipeline to stop issue and drain to a boundary.
- trap_ack  in  1  pipeline is at a boundary; pipe_pc is valid this cycle.
- pipe_pc  in  PC_WIDTH  PC of the next instruction to execute, i.e. the return address.
- mret_valid  in  1  single-cycle pulse when mret retires.
- trap_entry_en  out  1  one-cycle pulse to the CSR file to enter the trap.
- trap_exit_en  out  1  one-cycle pulse to the CSR file to exit the trap.
- int_index  out  4  cause index to load into mcause[3:0].
- normal_pc  out  PC_WIDTH  return PC to load into mepc.
- pending  out  NUM_IRQ  pending-request vector, for debug.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; pending=0; edge-detect register=0.
- Edge detect:
  - src_q registers irq_src every cycle.
  - new = irq_src & ~src_q.
  - pending <= (pending & ~clr) | new.
  - If set and clear hit the same bit in the same cycle, set wins.
- Eligibility: eligible = pending & irq_en.
  - Selection is fixed priority, lowest index wins.
  - Index is zero-extended to 4 bits.
- FSM states: IDLE, REQ, ENTRY, HANDLER, EXIT. All outputs are registered.
- IDLE:
  - int_mstatus_mie=1 and |eligible: latch sel_idx, go to REQ. trap_req is high from the next cycle.
  - Else if mret_valid: go to EXIT (returns from a software trap).
- REQ (trap_req=1):
  - mret_valid: highest priority. Drop trap_req, go to EXIT; pending is kept.
  - Else int_mstatus_mie=0: withdraw. trap_req goes low, return to IDLE.
  - Else trap_ack=1: normal_pc <= pipe_pc, int_index <= sel_idx, go to ENTRY, trap_req <= 0.
  - sel_idx stays frozen while in REQ; a higher-priority arrival does not re-arbitrate.
- ENTRY:
  - trap_entry_en=1 for exactly one cycle.
  - clr has a one-hot bit at sel_idx.
  - Next state is HANDLER.
- HANDLER:
  - Wait for mret_valid, then go to EXIT.
  - New requests keep latching into pending but are not serviced.
- EXIT:
  - trap_exit_en=1 for exactly one cycle, then IDLE.
  - Because the CSR restores MIE on that edge, the next arbitration sees the updated mie at the earliest one cycle later.
- Valid inputs in wrong states: trap_ack outside REQ is ignored; mret_valid in ENTRY is ignored.
- Latency, edge on irq_src first sampled at edge N:
  - pending visible after edge N.
  - REQ entered and trap_req=1 after edge N+1.
  - With trap_ack high in cycle M, trap_entry_en=1 in cycle M+1.
- int_index and normal_pc hold their values until the next ENTRY.
- Width rule: the clr mask and the priority encoder operate over NUM_IRQ bits; unused int_index bits are 0.

Optional Feature:
- Macro: IRQ_TRAP_CTRL_SYNC_EN.
- Defined: each irq_src bit passes through a 2-flop synchronizer (reset 0) before edge detect. This adds exactly 2 cycles to the request latency and suits asynchronous sources.
- Undefined: irq_src feeds edge detect directly. Sources must be synchronous to clk.

Test Plan (NUM_IRQ=16, macro undefined):
- Basic take: mie=1, irq_en=16'hFFFF, pulse irq_src[5].
  - trap_req high 2 cycles after the edge.
  - Ack with pipe_pc=32'h0000_0120 → trap_entry_en pulse, int_index=5, normal_pc=32'h120, pending[5]=0.
- Priority: raise irq_src[9] and irq_src[2] in the same cycle → int_index=2.
  - After mret/EXIT, a second trap is taken with int_index=9.
- Masking: mie=0 with irq_src[3] rising → no trap_req, pending[3]=1.
  - Set mie=1 → trap_req follows within 2 cycles.
  - With irq_en[3]=0 instead → no request at all.
- Withdraw and mret in REQ:
  - Drop mie while in REQ with no ack → trap_req falls, state returns to IDLE, pending retained.
  - Separately, mret_valid in REQ → trap_exit_en pulse, no trap_entry_en.
- No nesting: in HANDLER, pulse irq_src[0] → pending[0]=1, no trap_req until mret_valid.
  - After mret: trap_exit_en pulse, then trap_req with index 0.
- Reset mid-operation: assert rst while in REQ or HANDLER → trap_req, busy and pending all 0 immediately (asynchronous). The FSM restarts in IDLE.
